// File: rtl/task_8_pkg.sv
// Shared definitions for the task_8 result-output path: frame FSM states and sizing defaults.
package task_8_pkg;

    localparam int unsigned NUM_WORDS_DEF = 243;
    localparam int unsigned DEPTH_DEF     = 2 ** $clog2(NUM_WORDS_DEF);

    typedef enum logic [1:0] {
        s_IDLE,
        s_COLLECT,
        s_STREAM,
        s_DONE
    } state_e;

endpackage

// File: rtl/task_8_out_mem.sv
// Frame buffer: simple dual-port RAM, synchronous write, asynchronous read, no reset.
module task_8_out_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/task_8_out.sv
// Store-and-forward result framer: buffers a whole result frame, then streams it out with
// valid/ready handshaking and pulses o_output_last once the final word has been handed off.
module task_8_out
    import task_8_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    parameter int unsigned DEPTH      = 2 ** $clog2(NUM_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_last,
    output logic                  o_in_ready,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_output_last,
    output logic                  o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic            collecting;
    logic            accept;
    logic            full;
    logic            wr_en;
    logic            last_word;
    logic            handshake;

    assign collecting = (state_q == s_IDLE) || (state_q == s_COLLECT);
    // Held low while reset is asserted even though the FSM already sits in s_IDLE.
    assign o_in_ready = i_rst_n && collecting;
    assign accept     = o_in_ready && i_data_valid;
    assign full       = (count_q == FULL_COUNT);
    assign wr_en      = accept && !full;

    assign last_word     = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
    assign o_tvalid      = (state_q == s_STREAM);
    assign o_tlast       = o_tvalid && last_word;
    assign handshake     = o_tvalid && i_tready;
    assign o_output_last = (state_q == s_DONE);
    assign o_overflow    = overflow_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= s_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
            end
            if (accept && full) begin
                overflow_q <= 1'b1;
            end
            if (handshake) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case (state_q)
                s_IDLE, s_COLLECT: begin
                    // A dropped word carrying last still closes the frame.
                    if (accept) begin
                        state_q <= i_data_last ? s_STREAM : s_COLLECT;
                    end
                end
                s_STREAM: begin
                    if (handshake && last_word) begin
                        state_q <= s_DONE;
                    end
                end
                s_DONE: begin
                    state_q  <= s_IDLE;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end
                default: state_q <= s_IDLE;
            endcase
        end
    end

    task_8_out_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_tdata)
    );

endmodule

// File: tb/tb_task_8_out.sv
// Scoreboard bench for task_8_out: driver pushes the expected frame, a negedge monitor checks it.
module tb_task_8_out;

    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_last = 1'b0;
    logic       tready = 1'b1;
    logic       in_ready;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;
    logic       output_last;
    logic       overflow;

    int    checks = 0;
    int    failures = 0;
    int    handshakes = 0;
    int    tready_mode = 0;
    bit    exp_ovf = 1'b0;
    beat_t exp_q[$];

    task_8_out #(
        .DATA_WIDTH (8),
        .NUM_WORDS  (243)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_valid  (data_valid),
        .i_data        (data),
        .i_data_last   (data_last),
        .o_in_ready    (in_ready),
        .o_tvalid      (tvalid),
        .o_tdata       (tdata),
        .o_tlast       (tlast),
        .i_tready      (tready),
        .o_output_last (output_last),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at most DEPTH words of a frame survive; the last survivor carries tlast.
    task automatic expect_frame(input logic [7:0] words[$]);
        int n = words.size();
        int stored = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < stored; i++) begin
            exp_q.push_back('{data: words[i], last: (i == stored - 1)});
        end
    endtask

    task automatic send_frame(input logic [7:0] words[$], input bit gaps, output int cycles);
        int n = words.size();
        int cnt = 0;
        expect_frame(words);
        for (int i = 0; i < n; i++) begin
            // Idle gaps, sometimes with a stray last and no valid, which must be ignored.
            while (gaps && $urandom_range(0, 3) == 0) begin
                data_valid = 1'b0;
                data_last  = 1'($urandom_range(0, 1));
                data       = 8'($urandom);
                @(posedge clk); #1;
            end
            data_valid = 1'b1;
            data       = words[i];
            data_last  = (i == n - 1);
            @(posedge clk); #1;
            if (i >= DEPTH) exp_ovf = 1'b1;
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        check("tvalid_after_last", 32'(tvalid), 32'd1);
        // Words offered while streaming must be refused and leave the frame untouched.
        while (!output_last && cnt < 5000) begin
            data_valid = 1'($urandom_range(0, 1));
            data       = 8'($urandom);
            data_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cnt++;
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        check("output_last_seen", 32'(output_last), 32'd1);
        cycles = cnt;
        @(posedge clk); #1;
        check("output_last_one_cycle", 32'(output_last), 32'd0);
        check("in_ready_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        bit         prev_stall = 1'b0;
        bit         expect_ol = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        beat_t      b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                expect_ol  = 1'b0;
                continue;
            end
            check("output_last", 32'(output_last), 32'(expect_ol));
            expect_ol = 1'b0;
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (tvalid) check("in_ready_low_in_stream", 32'(in_ready), 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", 32'(tvalid), 32'd1);
                check("stall_data_held", 32'(tdata), 32'(prev_data));
                check("stall_last_held", 32'(tlast), 32'(prev_last));
            end
            if (tvalid && tready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", tdata, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("tdata", 32'(tdata), 32'(b.data));
                    check("tlast", 32'(tlast), 32'(b.last));
                    if (b.last) expect_ol = 1'b1;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    initial begin
        logic [7:0] w[$];
        int         sc;
        int         hs0;
        int         len;

        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_output_last", 32'(output_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Five-word frame, sink always ready: back-to-back output, fixed latency.
        tready_mode = 0;
        w = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        hs0 = handshakes;
        send_frame(w, 1'b0, sc);
        check("stream_cycles_5", 32'(sc), 32'd5);
        check("handshakes_5", 32'(handshakes - hs0), 32'd5);

        // Same frame with the sink toggling.
        tready_mode = 1;
        hs0 = handshakes;
        send_frame(w, 1'b0, sc);
        check("handshakes_toggle_5", 32'(handshakes - hs0), 32'd5);

        // One-word frame.
        tready_mode = 0;
        w = {8'hA5};
        send_frame(w, 1'b0, sc);
        check("stream_cycles_1", 32'(sc), 32'd1);

        // Random frames, random gaps, random backpressure.
        tready_mode = 2;
        repeat (20) begin
            len = $urandom_range(1, 24);
            w.delete();
            for (int i = 0; i < len; i++) w.push_back(8'($urandom));
            send_frame(w, 1'b1, sc);
        end

        // Reset after three collected words: nothing may come out.
        tready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data       = 8'(8'h30 + i);
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_tvalid", 32'(tvalid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_release", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_output", 32'(tvalid), 32'd0);
        w = {8'h10, 8'h11};
        send_frame(w, 1'b0, sc);
        check("midrst_next_frame_cycles", 32'(sc), 32'd2);

        // 257-word frame: the last word is dropped but still ends the frame.
        tready_mode = 2;
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back(8'(i));
        w.push_back(8'h00);
        send_frame(w, 1'b0, sc);
        check("overflow_set", 32'(overflow), 32'd1);

        tready_mode = 0;
        w = {8'h07, 8'h08};
        send_frame(w, 1'b0, sc);
        check("overflow_sticky", 32'(overflow), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        exp_ovf = 1'b0;
        #1;
        check("overflow_cleared_by_reset", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/task_8_out.md
TASK_8_OUT -- requirements
Module: task_8_out

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of result word and output stream data.
REQ-002 Parameter NUM_WORDS, default 243, maximum words per result frame.
REQ-003 Parameter DEPTH, default 2**$clog2(NUM_WORDS) (256), buffer capacity in words.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_data_valid  input  1  result word present on i_data this cycle.
REQ-008 i_data  input  DATA_WIDTH  result word from processing core.
REQ-009 i_data_last  input  1  qualifies final word of result frame (valid only with i_data_valid).
REQ-010 o_in_ready  output  1  block accepts result words this cycle.
REQ-011 o_tvalid  output  1  output stream word valid.
REQ-012 o_tdata  output  DATA_WIDTH  output stream data.
REQ-013 o_tlast  output  1  marks final output word of frame.
REQ-014 i_tready  input  1  downstream sink accepts word.
REQ-015 o_output_last  output  1  one-cycle pulse after final word handed off; drives task_8_in i_output_last.
REQ-016 o_overflow  output  1  sticky flag: a result word was dropped because buffer was full.

Function
REQ-017 Store-and-forward: a whole frame SHALL be buffered before any output word is presented.
REQ-018 FSM states: s_IDLE, s_COLLECT, s_STREAM, s_DONE.
REQ-019 s_IDLE: o_in_ready=1; accepted word (i_data_valid) -> s_COLLECT, or -> s_STREAM if i_data_last in same cycle.
REQ-020 s_COLLECT: o_in_ready=1; each i_data_valid writes one word, write pointer +1; i_data_last accepted -> s_STREAM next cycle.
REQ-021 Write to full buffer (count==DEPTH) SHALL be dropped, set o_overflow; i_data_last on dropped word still ends frame.
REQ-022 s_STREAM: o_in_ready=0, i_data_valid ignored; o_tvalid=1 from first cycle in state, o_tdata=mem[rd_ptr] combinationally.
REQ-023 Handshake = o_tvalid && i_tready; rd_ptr +1 per handshake; o_tdata/o_tlast SHALL hold stable while o_tvalid && !i_tready.
REQ-024 o_tlast=1 exactly when rd_ptr addresses the last stored word (stored count-1).
REQ-025 Handshake with o_tlast=1 -> s_DONE; s_DONE lasts one cycle with o_output_last=1, o_tvalid=0, then -> s_IDLE with pointers and count cleared.
REQ-026 Latency: i_data_last accepted at cycle N -> o_tvalid=1 at N+1; final handshake at M -> o_output_last=1 at M+1, o_in_ready=1 at M+2.
REQ-027 Word counter width $clog2(DEPTH)+1, no wrap; pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-028 One-word frame (i_data_valid && i_data_last in s_IDLE) SHALL stream one word with o_tlast=1.
REQ-029 i_data_last without i_data_valid SHALL be ignored.

Reset
REQ-030 While i_rst_n=0: state=s_IDLE, pointers/count=0, o_tvalid=0, o_tlast=0, o_output_last=0, o_overflow=0, o_in_ready=0.
REQ-031 Reset mid-frame (any state) SHALL discard buffered words; no o_output_last issued; o_in_ready=1 first cycle after release.
REQ-032 Buffer memory contents need not be reset.

Structure
REQ-033 Shared package task_8_pkg SHALL hold the FSM state enum and NUM_WORDS/DEPTH defaults.
REQ-034 One sub-module task_8_out_mem: simple dual-port RAM, synchronous write, asynchronous read, DEPTH x DATA_WIDTH.
REQ-035 Target size 150-300 lines RTL total.

Verification
REQ-036 Frame 0x01..0x05, last on 0x05, i_tready=1 -> o_tdata 0x01..0x05 on 5 consecutive cycles starting N+1, o_tlast with 0x05, o_output_last one cycle later.
REQ-037 Same frame, i_tready toggling 1,0,1,0 -> each word held stable while stalled, order unchanged, exactly 5 handshakes.
REQ-038 Single word 0xA5 with last in s_IDLE -> one output word 0xA5 with o_tlast=1, then o_output_last pulse.
REQ-039 257 words (0x00..0xFF, 0x00 with last) -> o_overflow=1, 256 words streamed, o_tlast on 0xFF, o_overflow stays 1 until reset.
REQ-040 i_rst_n low for 1 cycle after 3 words collected -> no output, o_output_last never pulses, next frame 0x10,0x11 streams correctly.
REQ-041 i_data_valid asserted during s_STREAM -> o_in_ready=0, word not stored, output frame unchanged.
